// File: rtl/re_pkg.sv
// rtl/re_pkg.sv - shared types and constants for the PUSCH RE grid mapper
package re_pkg;

  localparam int NSC_PER_RB = 12;
  localparam int NSYM       = 14;
  localparam int NSC_TOTAL  = 1200;
  localparam int ADDR_W     = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MAP,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_DATA,
    SRC_DMRS
  } src_t;

  // Row offset sym*nsc built from shifted copies of nsc, so no multiplier is inferred
  function automatic int sym_offset(input logic [3:0] sym, input int nsc);
    int acc;
    acc = 0;
    for (int b = 0; b < 4; b++) begin
      if (sym[b]) acc += nsc << b;
    end
    return acc;
  endfunction

endpackage

// File: rtl/re_sc_classifier.sv
// rtl/re_sc_classifier.sv - picks the sample source (DMRS, data or zero) for the current RE
module re_sc_classifier
  import re_pkg::*;
(
  input  logic dmrs_sym,
  input  logic rel_odd,
  input  logic dmrs_comb,
  input  logic data_en,
  output src_t src
);

  always_comb begin
    src = SRC_DATA;
    if (dmrs_sym) begin
      if (rel_odd == dmrs_comb) src = SRC_DMRS;
      else if (!data_en)        src = SRC_ZERO;
    end
  end

endmodule

// File: rtl/re_grid_mapper.sv
// rtl/re_grid_mapper.sv - maps DMRS and data streams onto allocated REs of one slot grid
module re_grid_mapper #(
  parameter int DATA_W    = 18,
  parameter int DMRS_W    = 9,
  parameter int NSC_TOTAL = re_pkg::NSC_TOTAL,
  parameter int NSYM      = re_pkg::NSYM,
  parameter int ADDR_W    = re_pkg::ADDR_W
) (
  input  logic              CLK_RE,
  input  logic              RST_RE,
  input  logic              Start,
  input  logic [10:0]       N_sc,
  input  logic [6:0]        N_rb,
  input  logic [3:0]        Sym_Start,
  input  logic [3:0]        Sym_End,
  input  logic [NSYM-1:0]   Dmrs_Sym_Mask,
  input  logic              Dmrs_Comb,
  input  logic              Dmrs_Data_En,
  input  logic [DMRS_W-1:0] Dmrs_I,
  input  logic [DMRS_W-1:0] Dmrs_Q,
  input  logic              Dmrs_Valid,
  output logic              Dmrs_Ready,
  input  logic [DATA_W-1:0] Data_I,
  input  logic [DATA_W-1:0] Data_Q,
  input  logic              Data_Valid,
  output logic              Data_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [DATA_W-1:0] Wr_I,
  output logic [DATA_W-1:0] Wr_Q,
  output logic              Busy,
  output logic              Sym_Done,
  output logic              RE_Done,
  output logic              Cfg_Err
);

  localparam int EXT_W = DATA_W - DMRS_W;

  re_pkg::state_t state_q, state_d;
  re_pkg::src_t   src;

  logic [10:0]       cfg_n_sc;
  logic [6:0]        cfg_n_rb;
  logic [3:0]        cfg_sym_start, cfg_sym_end;
  logic [NSYM-1:0]   cfg_mask;
  logic              cfg_comb, cfg_data_en;
  logic [3:0]        sym_q;
  logic [10:0]       sc_q;
  logic [ADDR_W-1:0] base_q;
  logic [11:0]       alloc_end;
  logic              cfg_bad, last_sc, advance;

  // alloc_end is one past the last allocated subcarrier: N_sc + 8*N_rb + 4*N_rb
  assign alloc_end = {1'b0, cfg_n_sc} + {2'b0, cfg_n_rb, 3'b0} + {3'b0, cfg_n_rb, 2'b0};
  assign cfg_bad   = (cfg_n_rb == 7'd0) || (int'(alloc_end) > NSC_TOTAL) ||
                     (cfg_sym_start > cfg_sym_end) || (int'(cfg_sym_end) >= NSYM);
  assign last_sc   = (({1'b0, sc_q} + 12'd1) == alloc_end);

  re_sc_classifier u_classifier (
    .dmrs_sym  (cfg_mask[sym_q]),
    .rel_odd   (sc_q[0] ^ cfg_n_sc[0]),
    .dmrs_comb (cfg_comb),
    .data_en   (cfg_data_en),
    .src       (src)
  );

  assign advance = (state_q == re_pkg::ST_MAP) &&
                   ((src == re_pkg::SRC_ZERO) ||
                    ((src == re_pkg::SRC_DMRS) && Dmrs_Valid) ||
                    ((src == re_pkg::SRC_DATA) && Data_Valid));

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) state_q <= re_pkg::ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      re_pkg::ST_IDLE:  if (Start) state_d = re_pkg::ST_CHECK;
      re_pkg::ST_CHECK: state_d = cfg_bad ? re_pkg::ST_IDLE : re_pkg::ST_MAP;
      re_pkg::ST_MAP:
        if (advance && last_sc)
          state_d = (sym_q == cfg_sym_end) ? re_pkg::ST_DONE : re_pkg::ST_NEXT;
      re_pkg::ST_NEXT:  state_d = re_pkg::ST_MAP;
      re_pkg::ST_DONE:  state_d = re_pkg::ST_IDLE;
      default:          state_d = re_pkg::ST_IDLE;
    endcase
  end

  always_comb begin
    Dmrs_Ready = 1'b0;
    Data_Ready = 1'b0;
    Sym_Done   = 1'b0;
    RE_Done    = 1'b0;
    Cfg_Err    = 1'b0;
    case (state_q)
      re_pkg::ST_CHECK: Cfg_Err = cfg_bad;
      re_pkg::ST_MAP: begin
        Dmrs_Ready = (src == re_pkg::SRC_DMRS);
        Data_Ready = (src == re_pkg::SRC_DATA);
      end
      re_pkg::ST_NEXT:  Sym_Done = 1'b1;
      // Last symbol skips NEXT, so DONE carries its Sym_Done alongside RE_Done
      re_pkg::ST_DONE: begin
        Sym_Done = 1'b1;
        RE_Done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy = (state_q != re_pkg::ST_IDLE);

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      cfg_n_sc      <= '0;
      cfg_n_rb      <= '0;
      cfg_sym_start <= '0;
      cfg_sym_end   <= '0;
      cfg_mask      <= '0;
      cfg_comb      <= 1'b0;
      cfg_data_en   <= 1'b0;
      sym_q         <= '0;
      sc_q          <= '0;
      base_q        <= '0;
      Wr_En         <= 1'b0;
      Wr_Addr       <= '0;
      Wr_I          <= '0;
      Wr_Q          <= '0;
    end else begin
      Wr_En <= advance;
      if (state_q == re_pkg::ST_IDLE && Start) begin
        cfg_n_sc      <= N_sc;
        cfg_n_rb      <= N_rb;
        cfg_sym_start <= Sym_Start;
        cfg_sym_end   <= Sym_End;
        cfg_mask      <= Dmrs_Sym_Mask;
        cfg_comb      <= Dmrs_Comb;
        cfg_data_en   <= Dmrs_Data_En;
      end
      if (state_q == re_pkg::ST_CHECK) begin
        sym_q  <= cfg_sym_start;
        sc_q   <= cfg_n_sc;
        base_q <= ADDR_W'(re_pkg::sym_offset(cfg_sym_start, NSC_TOTAL));
      end
      if (state_q == re_pkg::ST_NEXT) begin
        sym_q  <= sym_q + 4'd1;
        sc_q   <= cfg_n_sc;
        base_q <= base_q + ADDR_W'(NSC_TOTAL);
      end
      if (advance) begin
        sc_q    <= sc_q + 11'd1;
        Wr_Addr <= base_q + ADDR_W'(sc_q);
        case (src)
          re_pkg::SRC_DMRS: begin
            Wr_I <= {{EXT_W{Dmrs_I[DMRS_W-1]}}, Dmrs_I};
            Wr_Q <= {{EXT_W{Dmrs_Q[DMRS_W-1]}}, Dmrs_Q};
          end
          re_pkg::SRC_DATA: begin
            Wr_I <= Data_I;
            Wr_Q <= Data_Q;
          end
          default: begin
            Wr_I <= '0;
            Wr_Q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_re_grid_mapper.sv
// tb/tb_re_grid_mapper.sv - self-checking bench for re_grid_mapper against a slot-level reference model
module tb_re_grid_mapper;

  localparam int DATA_W    = 18;
  localparam int DMRS_W    = 9;
  localparam int NSC_TOTAL = 1200;
  localparam int NSYM      = 14;
  localparam int ADDR_W    = 15;

  logic              CLK_RE = 1'b0;
  logic              RST_RE;
  logic              Start;
  logic [10:0]       N_sc;
  logic [6:0]        N_rb;
  logic [3:0]        Sym_Start, Sym_End;
  logic [NSYM-1:0]   Dmrs_Sym_Mask;
  logic              Dmrs_Comb, Dmrs_Data_En;
  logic [DMRS_W-1:0] Dmrs_I, Dmrs_Q;
  logic              Dmrs_Valid, Dmrs_Ready;
  logic [DATA_W-1:0] Data_I, Data_Q;
  logic              Data_Valid, Data_Ready;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [DATA_W-1:0] Wr_I, Wr_Q;
  logic              Busy, Sym_Done, RE_Done, Cfg_Err;

  re_grid_mapper #(
    .DATA_W(DATA_W), .DMRS_W(DMRS_W), .NSC_TOTAL(NSC_TOTAL), .NSYM(NSYM), .ADDR_W(ADDR_W)
  ) dut (
    .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Start(Start),
    .N_sc(N_sc), .N_rb(N_rb), .Sym_Start(Sym_Start), .Sym_End(Sym_End),
    .Dmrs_Sym_Mask(Dmrs_Sym_Mask), .Dmrs_Comb(Dmrs_Comb), .Dmrs_Data_En(Dmrs_Data_En),
    .Dmrs_I(Dmrs_I), .Dmrs_Q(Dmrs_Q), .Dmrs_Valid(Dmrs_Valid), .Dmrs_Ready(Dmrs_Ready),
    .Data_I(Data_I), .Data_Q(Data_Q), .Data_Valid(Data_Valid), .Data_Ready(Data_Ready),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_I(Wr_I), .Wr_Q(Wr_Q),
    .Busy(Busy), .Sym_Done(Sym_Done), .RE_Done(RE_Done), .Cfg_Err(Cfg_Err)
  );

  always #5 CLK_RE = ~CLK_RE;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DMRS_W-1:0] dm_i [4096];
  logic [DMRS_W-1:0] dm_q [4096];
  logic [DATA_W-1:0] dt_i [8192];
  logic [DATA_W-1:0] dt_q [8192];
  int di = 0;
  int ti = 0;

  int                cap_addr[$];
  logic [DATA_W-1:0] cap_i[$], cap_q[$];
  int                exp_addr[$];
  logic [DATA_W-1:0] exp_i[$], exp_q[$];
  int exp_dmrs, exp_data;
  int n_symdone, n_redone, n_cfgerr, n_dmrs, n_data, n_both, n_align_err;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the allocation symbol by symbol and decide each RE from the placement rules
  function automatic void build_model(input int nsc, input int nrb, input int s0, input int s1,
                                      input logic [13:0] mask, input logic comb, input logic den,
                                      input int d0, input int t0);
    int dk, tk, vi, vq;
    dk = d0;
    tk = t0;
    exp_addr.delete(); exp_i.delete(); exp_q.delete();
    exp_dmrs = 0;
    exp_data = 0;
    for (int s = s0; s <= s1; s++) begin
      for (int sc = nsc; sc < nsc + 12 * nrb; sc++) begin
        exp_addr.push_back(s * NSC_TOTAL + sc);
        if (mask[s] && ((sc - nsc) % 2) == int'(comb)) begin
          vi = $signed(dm_i[dk]);
          vq = $signed(dm_q[dk]);
          exp_i.push_back(DATA_W'(vi));
          exp_q.push_back(DATA_W'(vq));
          dk++;
          exp_dmrs++;
        end else if (mask[s] && !den) begin
          exp_i.push_back('0);
          exp_q.push_back('0);
        end else begin
          exp_i.push_back(dt_i[tk]);
          exp_q.push_back(dt_q[tk]);
          tk++;
          exp_data++;
        end
      end
    end
  endfunction

  task automatic run_slot(input string tag, input int nsc, input int nrb, input int s0, input int s1,
                          input logic [13:0] mask, input logic comb, input logic den,
                          input int vmode, input bit exp_err, input int abort_at);
    int cyc, budget, end_cyc, redone_cyc, bad;
    bit done;
    cyc = 0; done = 0; end_cyc = -1; redone_cyc = -2;
    build_model(nsc, nrb, s0, s1, mask, comb, den, di, ti);
    cap_addr.delete(); cap_i.delete(); cap_q.delete();
    n_symdone = 0; n_redone = 0; n_cfgerr = 0; n_dmrs = 0; n_data = 0; n_both = 0; n_align_err = 0;
    N_sc = 11'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(s0); Sym_End = 4'(s1);
    Dmrs_Sym_Mask = mask; Dmrs_Comb = comb; Dmrs_Data_En = den;
    Start = 1'b1;
    @(posedge CLK_RE); #1;
    Start = 1'b0;
    budget = 40 * (12 * nrb + 2) * (s1 - s0 + 1) + 40;
    if (budget < 40) budget = 40;
    while (!done && cyc < budget) begin
      if (!Busy) begin
        done = 1;
        end_cyc = cyc;
      end else begin
        if (Wr_En) begin
          cap_addr.push_back(int'(Wr_Addr));
          cap_i.push_back(Wr_I);
          cap_q.push_back(Wr_Q);
        end
        if (Sym_Done) begin
          n_symdone++;
          if (!Wr_En || (int'(Wr_Addr) % NSC_TOTAL) != nsc + 12 * nrb - 1) n_align_err++;
        end
        if (RE_Done) begin
          n_redone++;
          redone_cyc = cyc;
          if (!Sym_Done) n_align_err++;
        end
        if (Cfg_Err) n_cfgerr++;
        Dmrs_Valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        Data_Valid = (vmode == 1) ? (cyc % 3 == 0) : (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        Dmrs_I = dm_i[di]; Dmrs_Q = dm_q[di];
        Data_I = dt_i[ti]; Data_Q = dt_q[ti];
        Start = (vmode == 2) && ($urandom_range(0, 7) == 0);
        #1;
        if (abort_at > 0 && cyc == abort_at) begin
          RST_RE = 1'b1;
          #1;
          check({tag, " outputs_in_reset"},
                {Wr_En, Wr_Addr, Wr_I, Wr_Q, Busy, Sym_Done, RE_Done, Cfg_Err, Dmrs_Ready, Data_Ready}, 0);
          Dmrs_Valid = 1'b0; Data_Valid = 1'b0; Start = 1'b0;
          @(posedge CLK_RE); #1;
          RST_RE = 1'b0;
          return;
        end
        if (Dmrs_Ready && Data_Ready) n_both++;
        if (Dmrs_Valid && Dmrs_Ready) begin di++; n_dmrs++; end
        if (Data_Valid && Data_Ready) begin ti++; n_data++; end
        @(posedge CLK_RE); #1;
        cyc++;
      end
    end
    Dmrs_Valid = 1'b0; Data_Valid = 1'b0; Start = 1'b0;
    check({tag, " terminated"}, done, 1);
    if (exp_err) begin
      check({tag, " cfg_err_pulses"}, n_cfgerr, 1);
      check({tag, " writes"}, cap_addr.size(), 0);
      check({tag, " busy_low_cycle"}, end_cyc, 1);
      check({tag, " handshakes"}, n_dmrs + n_data, 0);
    end else begin
      bad = 0;
      for (int k = 0; k < cap_addr.size() && k < exp_addr.size(); k++)
        if (cap_addr[k] != exp_addr[k] || cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k]) bad++;
      check({tag, " writes"}, cap_addr.size(), exp_addr.size());
      check({tag, " content_mismatches"}, bad, 0);
      check({tag, " dmrs_consumed"}, n_dmrs, exp_dmrs);
      check({tag, " data_consumed"}, n_data, exp_data);
      check({tag, " sym_done"}, n_symdone, s1 - s0 + 1);
      check({tag, " re_done"}, n_redone, 1);
      check({tag, " done_alignment_errs"}, n_align_err, 0);
      check({tag, " both_ready"}, n_both, 0);
      check({tag, " cfg_err"}, n_cfgerr, 0);
      check({tag, " re_done_then_idle"}, redone_cyc, end_cyc - 1);
    end
  endtask

  initial begin
    int nrb, nsc, s0, s1, d_before;
    RST_RE = 1'b1; Start = 1'b0;
    N_sc = '0; N_rb = '0; Sym_Start = '0; Sym_End = '0; Dmrs_Sym_Mask = '0;
    Dmrs_Comb = 1'b0; Dmrs_Data_En = 1'b0;
    Dmrs_I = '0; Dmrs_Q = '0; Dmrs_Valid = 1'b0; Data_I = '0; Data_Q = '0; Data_Valid = 1'b0;
    for (int k = 0; k < 4096; k++) begin dm_i[k] = DMRS_W'($urandom); dm_q[k] = DMRS_W'($urandom); end
    for (int k = 0; k < 8192; k++) begin dt_i[k] = DATA_W'($urandom); dt_q[k] = DATA_W'($urandom); end
    repeat (3) @(posedge CLK_RE);
    #1;
    check("reset wr", {Wr_En, Wr_Addr, Wr_I, Wr_Q}, 0);
    check("reset flags", {Busy, Sym_Done, RE_Done, Cfg_Err, Dmrs_Ready, Data_Ready}, 0);
    RST_RE = 1'b0;
    @(posedge CLK_RE); #1;

    run_slot("t1", 0, 1, 0, 3, 14'b1, 1'b0, 1'b0, 0, 0, 0);
    check("t1 n_writes", cap_addr.size(), 48);
    check("t1 n_dmrs", n_dmrs, 6);
    check("t1 n_data", n_data, 36);
    check("t1 n_symdone", n_symdone, 4);
    check("t1 sym0_odd_zero", {cap_i[1], cap_q[1]}, 0);

    run_slot("t2", 0, 1, 0, 3, 14'b1, 1'b0, 1'b1, 0, 0, 0);
    check("t2 n_dmrs", n_dmrs, 6);
    check("t2 n_data", n_data, 42);
    check("t2 sym0_odd_data", cap_i[1], dt_i[ti - 42]);

    d_before = di;
    dm_i[d_before] = 9'h100;
    run_slot("t3", 0, 1, 0, 0, 14'b1, 1'b0, 1'b0, 0, 0, 0);
    check("t3 dmrs_sign_ext", cap_i[0], 18'h3FF00);

    run_slot("t4", 1188, 1, 2, 5, 14'b00_0000_0010_0100, 1'b1, 1'b1, 0, 0, 0);
    check("t4 last_addr", cap_addr[cap_addr.size() - 1], 5 * 1200 + 1199);

    run_slot("e_nsc", 1190, 1, 0, 1, 14'b1, 1'b0, 1'b0, 0, 1, 0);
    run_slot("e_nrb0", 0, 0, 0, 1, 14'b1, 1'b0, 1'b0, 0, 1, 0);
    run_slot("e_symorder", 0, 2, 5, 4, 14'b1, 1'b0, 1'b0, 0, 1, 0);
    run_slot("e_symend", 0, 2, 10, 14, 14'b1, 1'b0, 1'b0, 0, 1, 0);

    run_slot("t_stall", 24, 2, 3, 6, 14'b00_0000_0010_1000, 1'b1, 1'b1, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      nrb = $urandom_range(1, 4);
      nsc = $urandom_range(0, NSC_TOTAL - 12 * nrb);
      s0  = $urandom_range(0, 12);
      s1  = s0 + $urandom_range(0, (13 - s0 < 3) ? 13 - s0 : 3);
      run_slot($sformatf("rnd%0d", r), nsc, nrb, s0, s1, 14'($urandom),
               1'($urandom), 1'($urandom), 2, 0, 0);
    end

    run_slot("abort", 100, 2, 1, 3, 14'b10, 1'b0, 1'b1, 0, 0, 5);
    run_slot("after_abort", 100, 2, 1, 3, 14'b10, 1'b0, 1'b1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
